a2_bus_sequencer: RTL and testbench
===================================

Name: a2_bus_sequencer

Overview:
- Upstream timing stage for the slot-card CPLD logic.
- Tracks the Apple II 6502 bus cycle from C7M and the delay-qualified PHI1, and produces the per-cycle state count S[2:0].
- Latches the card-select class and direction at the legal sample point, and emits the enable and strobe signals that the register/address-increment logic consumes.
- Also monitors cycle period and flags loss of bus synchronisation.

Parameters:
- NOMPER, 7: nominal C7M cycles between PHI1 rising edges.
- LONGPER, 8: long-cycle period (stretched cycle once per scan line).
- TIMEOUT, 15: C7M cycles without a PHI1 rise before sync is declared lost; 4-bit counter, max 15.

Ports:
- C7M  in  1  7.16 MHz clock; all state changes on the rising edge.
- nRES  in  1  reset. Asynchronous, active-low.
- PHI1  in  1  PHI1 with delayed rising edge, already qualified upstream.
- nDEVSEL  in  1  slot device select, active-low.
- nIOSEL  in  1  slot ROM select, active-low.
- nIOSTRB  in  1  expansion ROM strobe, active-low.
- nWE  in  1  6502 R/W; low = write.
- S  out  3  state: 0 = unsynced, 1-3 = PHI1 phase, 4-7 = PHI0 phase.
- Synced  out  1  PHI0 seen since reset and no timeout since.
- CSDBEN  out  1  chip-select / data-bus enable, high in S4-S7.
- DevAcc  out  1  latched ~nDEVSEL.
- IOAcc  out  1  latched ~nIOSEL.
- StrbAcc  out  1  latched ~nIOSTRB.
- WrAcc  out  1  latched ~nWE.
- WrStb  out  1  one-C7M pulse: write to any selected space.
- RdStb  out  1  one-C7M pulse: read of any selected space.
- CycleErr  out  1  sticky: a PHI1 period other than NOMPER/LONGPER was seen.

Behaviour:
- Reset: all registered outputs and internal state cleared.
  - S=0, Synced=0, CSDBEN=0, DevAcc/IOAcc/StrbAcc/WrAcc=0, WrStb=RdStb=0, CycleErr=0.
  - PHI1 history register=0, period counter=0.
  - Reset mid-cycle aborts any pending strobe immediately.
- PHI1 edge detect: PHI1q registers PHI1 each cycle; rise = PHI1 & ~PHI1q.
- PHI0seen: set on any cycle with PHI1=0; cleared only by reset or timeout.
- S update, priority order:
  - (1) timeout → 0.
  - (2) rise & PHI0seen → 1.
  - (3) S==0 holds 0.
  - (4) S==7 holds 7, which absorbs the long cycle.
  - (5) otherwise S+1.
- Synced = PHI0seen and S≠0 reached at least once since last reset/timeout.
- CSDBEN registered: next value = (next S in 4..7). Deasserts on the same edge S goes to 1.
- Sample point: on the edge where S==4 (entering S5), latch DevAcc/IOAcc/StrbAcc/WrAcc from the inputs. These flags hold through S5-S7.
- Flag clear: on the edge S becomes 1, all four flags clear. Inputs outside S4 are ignored.
- Strobes: on the edge where S==6, WrStb = WrAcc & (DevAcc|IOAcc|StrbAcc), and RdStb = ~WrAcc & (DevAcc|IOAcc|StrbAcc). Both are high for exactly one cycle (while S==7).
- Long cycle: the extra S7 cycle gives no second strobe.
- Period counter (4-bit):
  - Resets to 1 on rise; otherwise increments, saturating at 15.
  - On rise with PHI0seen and counter value ∉ {NOMPER, LONGPER}, set CycleErr. The first rise after reset/timeout is exempt.
- Timeout: counter reaches TIMEOUT with no rise → S=0, PHI0seen=0, Synced=0, flags cleared, CycleErr preserved.
- Simultaneous events: a rise on the same edge as S==6 still produces the strobe, and resync wins for S.

Test Plan:
- Reset then 10 normal cycles (PHI1 high 4 C7M of a 7-C7M period) → sequence:
  - S: 0 until first rise after PHI1 low; then 1,2,3,4,5,6,7 repeating.
  - CSDBEN high exactly in S4-S7.
  - CycleErr=0.
- Long cycle (8-C7M period) inserted → S sits in 7 for two cycles; one strobe per cycle; CycleErr stays 0.
- nDEVSEL=0, nWE=0 held S3-S6 → DevAcc=1, WrAcc=1 from S5; WrStb one pulse during S7; RdStb=0.
- nIOSEL=0 asserted only in S2, deasserted by S4 → IOAcc=0, no strobe.
- Read via nIOSTRB=0 → RdStb pulse in S7; flags clear when S returns to 1.
- Stop PHI1 toggling for 20 cycles → S=0, Synced=0 at count 15.
  - Restart with period 5 → resync to S=1 on first rise, no error.
  - Next period 5 → CycleErr=1, sticky until nRES.
- nRES low during S6 of a write → WrStb never asserts; all outputs 0.

Source files
------------

// File: rtl/a2_bus_sequencer.sv
// Apple II slot bus cycle tracker: derives the S[2:0] phase count from C7M/PHI1,
// latches the card-select class at the sample point and issues read/write strobes.
module a2_bus_sequencer #(
    parameter int NOMPER  = 7,
    parameter int LONGPER = 8,
    parameter int TIMEOUT = 15
) (
    input  logic       C7M,
    input  logic       nRES,
    input  logic       PHI1,
    input  logic       nDEVSEL,
    input  logic       nIOSEL,
    input  logic       nIOSTRB,
    input  logic       nWE,
    output logic [2:0] S,
    output logic       Synced,
    output logic       CSDBEN,
    output logic       DevAcc,
    output logic       IOAcc,
    output logic       StrbAcc,
    output logic       WrAcc,
    output logic       WrStb,
    output logic       RdStb,
    output logic       CycleErr
);

    localparam logic [3:0] NOM4    = 4'(NOMPER);
    localparam logic [3:0] LONG4   = 4'(LONGPER);
    localparam logic [3:0] TMO_PRE = 4'(TIMEOUT - 1);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic       phi1q;
    logic       phi0seen;
    logic       armed;
    logic [3:0] cnt;

    logic       rise;
    logic       timeout;
    logic       any_sel;
    logic [2:0] s_nxt;
    logic       phi0seen_nxt;
    logic       armed_nxt;
    logic [3:0] cnt_nxt;
    logic       synced_nxt;
    logic       csdben_nxt;
    logic [3:0] flags_nxt;
    logic       wrstb_nxt;
    logic       rdstb_nxt;
    logic       cycerr_nxt;

    assign rise    = PHI1 & ~phi1q;
    // Fires once as the counter steps onto TIMEOUT; the saturated counter then stays quiet.
    assign timeout = ~rise & (cnt == TMO_PRE);
    assign any_sel = DevAcc | IOAcc | StrbAcc;

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            S        <= 3'd0;
            phi1q    <= 1'b0;
            phi0seen <= 1'b0;
            armed    <= 1'b0;
            cnt      <= 4'd0;
            Synced   <= 1'b0;
            CSDBEN   <= 1'b0;
            DevAcc   <= 1'b0;
            IOAcc    <= 1'b0;
            StrbAcc  <= 1'b0;
            WrAcc    <= 1'b0;
            WrStb    <= 1'b0;
            RdStb    <= 1'b0;
            CycleErr <= 1'b0;
        end else begin
            S        <= s_nxt;
            phi1q    <= PHI1;
            phi0seen <= phi0seen_nxt;
            armed    <= armed_nxt;
            cnt      <= cnt_nxt;
            Synced   <= synced_nxt;
            CSDBEN   <= csdben_nxt;
            {DevAcc, IOAcc, StrbAcc, WrAcc} <= flags_nxt;
            WrStb    <= wrstb_nxt;
            RdStb    <= rdstb_nxt;
            CycleErr <= cycerr_nxt;
        end
    end

    always_comb begin
        s_nxt = S;
        if (timeout)
            s_nxt = 3'd0;
        else if (rise && phi0seen)
            s_nxt = 3'd1;
        else if (S == 3'd0)
            s_nxt = 3'd0;
        else if (S == 3'd7)
            s_nxt = 3'd7;   // S7 absorbs the stretched cycle
        else
            s_nxt = S + 3'd1;

        phi0seen_nxt = timeout ? 1'b0 : (phi0seen | ~PHI1);
        // The first real rise after reset/timeout only arms the period check.
        armed_nxt    = timeout ? 1'b0 : (armed | (rise & phi0seen));
        cnt_nxt      = rise ? 4'd1 : sat_inc4(cnt);
    end

    always_comb begin
        synced_nxt = ~timeout & (Synced | (s_nxt != 3'd0));
        csdben_nxt = s_nxt[2];

        flags_nxt = {DevAcc, IOAcc, StrbAcc, WrAcc};
        if (timeout || s_nxt == 3'd1)
            flags_nxt = 4'b0000;
        else if (S == 3'd4)
            flags_nxt = {~nDEVSEL, ~nIOSEL, ~nIOSTRB, ~nWE};

        // Strobes are decided from the flags as they stand in S6, even if a resync lands here.
        wrstb_nxt = (S == 3'd6) &  WrAcc & any_sel;
        rdstb_nxt = (S == 3'd6) & ~WrAcc & any_sel;

        cycerr_nxt = CycleErr |
                     (rise & phi0seen & armed & ~((cnt == NOM4) | (cnt == LONG4)));
    end

endmodule

// File: tb/tb_a2_bus_sequencer.sv
// Directed bench for a2_bus_sequencer: phase sequence, select latching, strobes,
// long cycles, timeout/resync, period errors and reset during a write.
module tb_a2_bus_sequencer;

    logic       C7M;
    logic       nRES;
    logic       PHI1;
    logic       nDEVSEL;
    logic       nIOSEL;
    logic       nIOSTRB;
    logic       nWE;
    logic [2:0] S;
    logic       Synced;
    logic       CSDBEN;
    logic       DevAcc;
    logic       IOAcc;
    logic       StrbAcc;
    logic       WrAcc;
    logic       WrStb;
    logic       RdStb;
    logic       CycleErr;

    int n_chk  = 0;
    int n_pass = 0;

    a2_bus_sequencer #(.NOMPER(7), .LONGPER(8), .TIMEOUT(15)) dut (
        .C7M(C7M), .nRES(nRES), .PHI1(PHI1),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB), .nWE(nWE),
        .S(S), .Synced(Synced), .CSDBEN(CSDBEN),
        .DevAcc(DevAcc), .IOAcc(IOAcc), .StrbAcc(StrbAcc), .WrAcc(WrAcc),
        .WrStb(WrStb), .RdStb(RdStb), .CycleErr(CycleErr)
    );

    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick(input logic phi);
        PHI1 = phi;
        @(posedge C7M);
        #1;
    endtask

    task automatic deselect();
        nDEVSEL = 1'b1;
        nIOSEL  = 1'b1;
        nIOSTRB = 1'b1;
        nWE     = 1'b1;
    endtask

    // One bus cycle starting at a PHI1 rise: 4 high clocks, nlow low clocks.
    // Selects are held from S3 to S6; io_early pulses nIOSEL during S2 only.
    task automatic period(input int nlow, input logic dev, input logic io,
                          input logic strb, input logic we, input logic io_early,
                          input logic [3:0] xflags, input logic xw, input logic xr);
        deselect();
        for (int i = 1; i <= 4; i++) begin
            if (i == 3 && io_early) nIOSEL = 1'b0;
            if (i == 4) begin
                nDEVSEL = ~dev;
                nIOSEL  = ~io;
                nIOSTRB = ~strb;
                nWE     = ~we;
            end
            tick(1'b1);
            check("S_phi1", 4'(S), 4'(i));
            check("CSDBEN_phi1", 4'(CSDBEN), 4'(i == 4));
            check("flags_phi1", {DevAcc, IOAcc, StrbAcc, WrAcc}, 4'b0000);
            check("WrStb_phi1", 4'(WrStb), 4'd0);
            check("RdStb_phi1", 4'(RdStb), 4'd0);
        end
        for (int i = 0; i < nlow; i++) begin
            if (i == 3) deselect();
            tick(1'b0);
            check("S_phi0", 4'(S), (i + 5 > 7) ? 4'd7 : 4'(i + 5));
            check("CSDBEN_phi0", 4'(CSDBEN), 4'd1);
            check("flags_phi0", {DevAcc, IOAcc, StrbAcc, WrAcc}, xflags);
            check("WrStb_phi0", 4'(WrStb), (i == 2) ? 4'(xw) : 4'd0);
            check("RdStb_phi0", 4'(RdStb), (i == 2) ? 4'(xr) : 4'd0);
        end
        deselect();
    endtask

    initial begin
        nRES = 1'b0;
        PHI1 = 1'b0;
        deselect();

        // Reset state
        @(posedge C7M); #1;
        @(posedge C7M); #1;
        check("rst_S", 4'(S), 4'd0);
        check("rst_Synced", 4'(Synced), 4'd0);
        check("rst_CSDBEN", 4'(CSDBEN), 4'd0);
        check("rst_flags", {DevAcc, IOAcc, StrbAcc, WrAcc}, 4'b0000);
        check("rst_strobes", {2'b00, WrStb, RdStb}, 4'b0000);
        check("rst_CycleErr", 4'(CycleErr), 4'd0);
        nRES = 1'b1;

        // PHI0 seen but no rise yet: still unsynced
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            check("pre_S", 4'(S), 4'd0);
            check("pre_Synced", 4'(Synced), 4'd0);
        end

        // Ten nominal cycles, no selects
        for (int n = 0; n < 10; n++)
            period(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("norm_Synced", 4'(Synced), 4'd1);
        check("norm_CycleErr", 4'(CycleErr), 4'd0);

        // Long cycle carrying a device write: one strobe only
        period(4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b1, 1'b0);
        // Nominal device write
        period(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b1, 1'b0);
        // nIOSEL only in S2: ignored
        period(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        // Expansion ROM read, then a plain cycle whose S1 shows flags cleared
        period(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1);
        period(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        // Slot ROM read
        period(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);
        check("long_CycleErr", 4'(CycleErr), 4'd0);

        // PHI1 stops low: timeout on the 14th clock after the rise
        for (int k = 0; k < 4; k++) tick(1'b1);
        for (int k = 0; k < 17; k++) begin
            tick(1'b0);
            if (k == 9) begin
                check("tmo_before_S", 4'(S), 4'd7);
                check("tmo_before_Synced", 4'(Synced), 4'd1);
            end
            if (k == 10) begin
                check("tmo_S", 4'(S), 4'd0);
                check("tmo_Synced", 4'(Synced), 4'd0);
                check("tmo_CSDBEN", 4'(CSDBEN), 4'd0);
            end
        end
        check("tmo_hold_S", 4'(S), 4'd0);
        check("tmo_CycleErr", 4'(CycleErr), 4'd0);

        // Restart with period 5: first rise resyncs without error, second flags it
        tick(1'b1);
        check("resync_S", 4'(S), 4'd1);
        check("resync_Synced", 4'(Synced), 4'd1);
        check("resync_CycleErr", 4'(CycleErr), 4'd0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("p5_S", 4'(S), 4'd5);
        tick(1'b1);
        check("p5_rise_S", 4'(S), 4'd1);
        check("p5_CycleErr", 4'(CycleErr), 4'd1);

        // Rise coincident with S6 of a write: strobe still issued, S resyncs
        tick(1'b1);
        tick(1'b1);
        nDEVSEL = 1'b0;
        nWE     = 1'b0;
        tick(1'b1);
        tick(1'b0);
        check("sim_flags", {DevAcc, IOAcc, StrbAcc, WrAcc}, 4'b1001);
        tick(1'b0);
        check("sim_S6", 4'(S), 4'd6);
        tick(1'b1);
        check("sim_S", 4'(S), 4'd1);
        check("sim_WrStb", 4'(WrStb), 4'd1);
        check("sim_flags_clr", {DevAcc, IOAcc, StrbAcc, WrAcc}, 4'b0000);
        check("sim_CycleErr", 4'(CycleErr), 4'd1);

        // Reset asserted in S6 of a write
        deselect();
        tick(1'b1);
        check("wr2_WrStb_off", 4'(WrStb), 4'd0);
        tick(1'b1);
        nDEVSEL = 1'b0;
        nWE     = 1'b0;
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("wr2_S", 4'(S), 4'd6);
        check("wr2_flags", {DevAcc, IOAcc, StrbAcc, WrAcc}, 4'b1001);
        check("wr2_CycleErr", 4'(CycleErr), 4'd1);
        nRES = 1'b0;
        #1;
        check("arst_S", 4'(S), 4'd0);
        check("arst_CSDBEN", 4'(CSDBEN), 4'd0);
        check("arst_flags", {DevAcc, IOAcc, StrbAcc, WrAcc}, 4'b0000);
        check("arst_Synced", 4'(Synced), 4'd0);
        check("arst_CycleErr", 4'(CycleErr), 4'd0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            check("arst_WrStb", 4'(WrStb), 4'd0);
            check("arst_hold_S", 4'(S), 4'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
